alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Control-side counterpart of the enable-gated 4-bit function units (AND, OR, XOR, NOT, ADD, SUB) in the 4-bit ALU.
- Accepts one operation per valid/ready handshake and registers the operands. Drives them and exactly one unit enable, waits a programmable settle time, then captures the OR-combined unit result.
- Presents the captured result with flags on a second valid/ready handshake.
- Sits between the front-end command source and the function-unit array.

Parameters:
- SETTLE_CYCLES, 1, cycles the unit enable is held before the result is sampled; legal range 1..15.
- CHAIN_EN, 1, when 1, opcode bit 3 selects the previous result as operand B.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  command present.
- op_ready  output  1  sequencer can accept a command.
- opcode  input  4  [2:0] = operation, [3] = chain (B := last result).
- a_in  input  4  operand A.
- b_in  input  4  operand B.
- A0, A1, A2, A3  output  1 each  registered operand A to the units.
- B0, B1, B2, B3  output  1 each  registered operand B to the units.
- en_and, en_or, en_xor, en_not, en_add, en_sub  output  1 each  unit enables, at most one high.
- y_in  input  4  OR of all unit Y outputs; disabled units drive 0.
- cout_in  input  1  carry/borrow from the add/sub unit; 0 otherwise.
- res_valid  output  1  result held.
- res_ready  input  1  consumer accepts the result.
- result  output  4  captured result.
- flag_zero  output  1  result == 4'b0000.
- flag_carry  output  1  captured cout_in; forced 0 for logic ops.
- flag_illegal  output  1  opcode[2:0] was 3'b110 or 3'b111.

Behaviour:
- Opcode[2:0] mapping: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 ADD, 101 SUB, 110/111 illegal.
- Reset values: all enables 0; A*/B* 0; op_ready 1; res_valid 0; result 0; all flags 0; last-result register 0; FSM in IDLE.
- FSM states: IDLE, ISSUE, SETTLE, HOLD.
- IDLE:
  - op_ready = 1.
  - On op_valid & op_ready: latch a_in into A* and latch operand B. Operand B is the last-result register if CHAIN_EN=1 and opcode[3]=1; otherwise it is b_in.
  - Latch opcode, then go to ISSUE.
  - op_ready drops to 0 the cycle after acceptance.
- ISSUE:
  - Legal opcode: assert the selected enable, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - Illegal opcode: no enable. Capture result=0, flag_illegal=1, flag_zero=1, flag_carry=0, go to HOLD.
- SETTLE:
  - Enable held high.
  - Counter nonzero: decrement and stay.
  - Counter zero: capture result=y_in and flag_carry=cout_in (add/sub only), compute flag_zero, set flag_illegal=0. Load the last-result register, drop the enable, go to HOLD.
- HOLD:
  - res_valid = 1; result and flags stable while res_valid=1 and res_ready=0.
  - On res_ready: res_valid falls next cycle, FSM returns to IDLE, op_ready returns to 1.
- Latency: with SETTLE_CYCLES=1, acceptance at cycle N gives enable high at N+1 and res_valid at N+2 (3 cycles accept-to-result).
- No overlap: one operation in flight. op_valid while op_ready=0 is ignored; the source must hold it.
- Enable timing: an enable is never high outside ISSUE/SETTLE. Enables are registered, so no glitches.
- Chaining: the last-result register updates only on a legal capture. An illegal op leaves it unchanged.
- Reset mid-operation (any state) returns to reset values in the next cycle, discarding the operation; no res_valid is produced.
- res_ready while res_valid=0 has no effect.
- Width: all data is 4 bits; unit carry-out is taken only from cout_in.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_AND..OP_SUB;
  - the FSM state encoding;
  - the SETTLE counter width (4).
- One natural sub-module, alu_op_decode: combinational opcode[2:0] to one-hot enable vector plus illegal flag. The sequencer registers its output.

Test Plan:
- AND: reset, then a=1100, b=1010, op=0000, res_ready=1 → en_and high exactly 1 cycle, result=1000, zero=0, carry=0, res_valid 2 cycles after accept.
- ADD overflow then chained SUB:
  - a=1111, b=0001, op=0100 → result=0000, carry=1, zero=1.
  - Then a=0011, op=1101 (chain) → B=0000, result=0011, borrow per unit.
- Illegal opcode: op=0111 → no enable ever high, result=0000, flag_illegal=1. A following chained op still uses the pre-illegal last result.
- Backpressure: hold res_ready=0 for 5 cycles → res_valid and result stable, op_ready=0, a new op_valid is ignored. When res_ready=1, the next op is accepted one cycle after IDLE is re-entered.
- SETTLE_CYCLES=4: XOR a=0110, b=0101 → en_xor high 4 consecutive cycles, result=0011 sampled on the 4th.
- Reset asserted during SETTLE → enables drop and all outputs return to reset values next cycle, res_valid never asserts, op_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, enable
// vector layout, FSM state encoding and settle counter width.
package alu_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Bit positions inside the one-hot unit enable vector.
    localparam int EN_AND = 0;
    localparam int EN_OR  = 1;
    localparam int EN_XOR = 2;
    localparam int EN_NOT = 3;
    localparam int EN_ADD = 4;
    localparam int EN_SUB = 5;
    localparam int EN_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot function unit enable plus an
// illegal-opcode indication for the two unused encodings.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0]      op,
    output logic [EN_W-1:0] en_vec,
    output logic            illegal
);

    // Map the operation field onto exactly one unit enable.
    always_comb begin
        en_vec  = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  en_vec[EN_AND] = 1'b1;
            OP_OR:   en_vec[EN_OR]  = 1'b1;
            OP_XOR:  en_vec[EN_XOR] = 1'b1;
            OP_NOT:  en_vec[EN_NOT] = 1'b1;
            OP_ADD:  en_vec[EN_ADD] = 1'b1;
            OP_SUB:  en_vec[EN_SUB] = 1'b1;
            default: illegal        = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer for the enable-gated 4-bit function unit array.
//
// state  | meaning
// IDLE   | waiting for a command, op_ready high
// ISSUE  | operands latched, decode registered into the unit enables
// SETTLE | one enable high, settle counter running down to zero
// HOLD   | result and flags presented with res_valid until res_ready
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit CHAIN_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] opcode,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       B0,
    output logic       B1,
    output logic       B2,
    output logic       B3,
    output logic       en_and,
    output logic       en_or,
    output logic       en_xor,
    output logic       en_not,
    output logic       en_add,
    output logic       en_sub,
    input  logic [3:0] y_in,
    input  logic       cout_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] result,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       flag_illegal
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t       state_q, state_n;
    logic [2:0]       op_q, op_n;
    logic [3:0]       a_q, a_n;
    logic [3:0]       b_q, b_n;
    logic [EN_W-1:0]  en_q, en_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       result_q, result_n;
    logic             zero_q, zero_n;
    logic             carry_q, carry_n;
    logic             illegal_q, illegal_n;
    logic [3:0]       last_q, last_n;

    logic [EN_W-1:0]  dec_en;
    logic             dec_illegal;

    alu_op_decode u_decode (
        .op      (op_q),
        .en_vec  (dec_en),
        .illegal (dec_illegal)
    );

    // Next-state and datapath update; everything holds unless a state acts.
    always_comb begin
        state_n   = state_q;
        op_n      = op_q;
        a_n       = a_q;
        b_n       = b_q;
        en_n      = en_q;
        cnt_n     = cnt_q;
        result_n  = result_q;
        zero_n    = zero_q;
        carry_n   = carry_q;
        illegal_n = illegal_q;
        last_n    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    a_n     = a_in;
                    b_n     = (CHAIN_EN && opcode[3]) ? last_q : b_in;
                    op_n    = opcode[2:0];
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dec_illegal) begin
                    result_n  = 4'b0000;
                    zero_n    = 1'b1;
                    carry_n   = 1'b0;
                    illegal_n = 1'b1;
                    state_n   = ST_HOLD;
                end else begin
                    en_n    = dec_en;
                    cnt_n   = SETTLE_LOAD;
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else begin
                    result_n  = y_in;
                    zero_n    = (y_in == 4'b0000);
                    // Logic units have no carry; ignore whatever is on cout_in.
                    carry_n   = cout_in & (dec_en[EN_ADD] | dec_en[EN_SUB]);
                    illegal_n = 1'b0;
                    last_n    = y_in;
                    en_n      = '0;
                    state_n   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                en_n    = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'b000;
            a_q       <= 4'b0000;
            b_q       <= 4'b0000;
            en_q      <= '0;
            cnt_q     <= '0;
            result_q  <= 4'b0000;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            last_q    <= 4'b0000;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            a_q       <= a_n;
            b_q       <= b_n;
            en_q      <= en_n;
            cnt_q     <= cnt_n;
            result_q  <= result_n;
            zero_q    <= zero_n;
            carry_q   <= carry_n;
            illegal_q <= illegal_n;
            last_q    <= last_n;
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_HOLD);

    assign {A3, A2, A1, A0} = a_q;
    assign {B3, B2, B1, B0} = b_q;

    assign en_and = en_q[EN_AND];
    assign en_or  = en_q[EN_OR];
    assign en_xor = en_q[EN_XOR];
    assign en_not = en_q[EN_NOT];
    assign en_add = en_q[EN_ADD];
    assign en_sub = en_q[EN_SUB];

    assign result       = result_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;
    assign flag_illegal = illegal_q;

endmodule
